dnn_sched: RTL and testbench
============================

// Module: dnn_sched
// PURPOSE
//  Shares one two-stage dnn datapath (layer-1 MAC+ReLU, then output MAC) among NUM_REQ requesters.
//  Round-robin arbiter issues at most one input vector per cycle and drives the datapath's in_ready pulse.
//  Feeds the ReLU outputs back as the aggregate inputs (single-node aggregation).
//  Tags each issue with its requester ID; results return in order through a credit-protected FIFO.
//  Sits between the requester fabric and the dnn instance.
// PARAMETERS
//  NUM_REQ    4  number of requesters (2..8)
//  RES_DEPTH  4  result FIFO entries (>=2, power of 2)
//  ID_W       $clog2(NUM_REQ)  requester tag width (derived, not overridable)
// PORTS
//  clk           in   1               rising-edge clock
//  rst           in   1               asynchronous reset, active-high
//  req_valid     in   NUM_REQ         per-requester request valid
//  req_ready     out  NUM_REQ         per-requester accept (one-hot or zero)
//  req_x         in   NUM_REQ*28      per-requester {x3,x2,x1,x0}, signed 7b each, requester i at [28i+:28]
//  dnn_x0..x3    out  7 each          muxed inputs to datapath
//  dnn_in_ready  out  1               issue strobe to datapath
//  dnn_y4..7_relu in  15 each         datapath ReLU outputs
//  dnn_y4..7_aggr out 17 each         aggregate inputs returned to datapath
//  dnn_out0/1    in   21 each         datapath output registers (signed)
//  res_valid     out  1               FIFO head valid
//  res_ready     in   1               consumer accept
//  res_id        out  ID_W            requester tag of head result
//  res_out0/1    out  21 each         head result, signed
// BEHAVIOUR
//  Reset: req_ready=0, dnn_in_ready=0, dnn_x*=0, res_valid=0, RR pointer=0, FIFO empty, pipe valids=0.
//  Reset mid-operation drops in-flight and queued results; no result is emitted for them.
//  Issue condition: any req_valid && (fifo_count + inflight) < RES_DEPTH; inflight = pipe valid stages (0..2).
//  Grant: first valid requester at or after RR pointer (wrapping); pointer <- grant+1 mod NUM_REQ.
//  req_ready[g], dnn_in_ready, dnn_x* are combinational in the issue cycle T; transfer = req_valid&req_ready.
//  No grant: dnn_in_ready=0, dnn_x* hold 0, pointer unchanged.
//  Pipeline: tag/valid stage1 at T+1 (y*_relu valid); stage2 at T+2 (dnn_out* valid, pushed to FIFO).
//  dnn_y*_aggr = zero-extend(dnn_y*_relu) (ReLU output is non-negative; upper bits 0).
//  Datapath output-ready flags are unreset, so they are ignored; only internal pipe valids are trusted.
//  FIFO push at stage2, pop on res_valid&res_ready; simultaneous push+pop keeps count. Head is registered.
//  Credit rule guarantees no push while full; full-FIFO push is an assertion error.
//  Back-to-back issue every cycle is sustained while res_ready=1 and RES_DEPTH>=3.
//  Result ordering = issue ordering; latency issue->res_valid = 3 cycles when FIFO empty.
//  Arithmetic is owned by datapath; block does no math beyond zero-extension and counter updates.
// CONFIGURATION
//  DNN_SCHED_PERF_EN defined: adds outputs perf_issue_cnt[31:0] (transfers) and
//   perf_stall_cnt[31:0] (cycles with any req_valid but credit blocked); both reset to 0, wrap at 2^32.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package dnn_sched_pkg: X_W=7, RELU_W=15, AGGR_W=17, OUT_W=21, typedef res_t {id, out0, out1}.
//  Sub-module dnn_sched_rr_arb (NUM_REQ req -> one-hot grant, pointer advance on accept).
//  FIFO, credit counter and tag pipe are inline.
// TESTING
//  Single req0 x={1,2,3,4}, weights all 1 -> res_valid at T+3, res_id=0, out0=out1=4*10=40.
//  All 4 req_valid held, res_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; res_id same order.
//  res_ready=0, req0 streaming, RES_DEPTH=4 -> exactly 4 transfers then req_ready=0; resume on res_ready=1.
//  Negative layer-1 sum (x0=-5, w04=1, others 0) -> y4_aggr=0 fed back, out0=0.
//  Assert rst while 2 issues are in flight -> res_valid stays 0 after release; next issue gives latency 3.
//  PERF_EN build: 3 credit-blocked cycles + 5 transfers -> perf_stall_cnt=3, perf_issue_cnt=5.

Source files
------------

// File: rtl/dnn_sched_pkg.sv
// Shared widths and the result-FIFO record for the dnn datapath scheduler.
// MAX_ID_W covers the largest supported requester count (8).
package dnn_sched_pkg;

  localparam int X_W      = 7;
  localparam int RELU_W   = 15;
  localparam int AGGR_W   = 17;
  localparam int OUT_W    = 21;
  localparam int VEC_W    = 4 * X_W;
  localparam int MAX_ID_W = 3;

  typedef struct packed {
    logic [MAX_ID_W-1:0]     id;
    logic signed [OUT_W-1:0] out0;
    logic signed [OUT_W-1:0] out1;
  } res_t;

  // ReLU outputs are never negative, so widening is a plain zero-extension.
  function automatic logic [AGGR_W-1:0] relu_to_aggr(input logic [RELU_W-1:0] v);
    return {{(AGGR_W - RELU_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/dnn_sched_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
// The pointer moves past the winner whenever a grant is issued.
module dnn_sched_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic                       i_en,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic [$clog2(NUM_REQ)-1:0] o_gnt_idx,
  output logic                       o_gnt_valid
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] r_ptr;

  // Scan from farthest to nearest so the closest valid requester wins last.
  always_comb begin
    int idx;
    idx         = 0;
    o_gnt       = '0;
    o_gnt_idx   = '0;
    o_gnt_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(r_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (i_en && i_req[ID_W'(idx)]) begin
        o_gnt_idx   = ID_W'(idx);
        o_gnt_valid = 1'b1;
      end
    end
    if (o_gnt_valid) o_gnt[o_gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (o_gnt_valid) begin
      r_ptr <= (int'(o_gnt_idx) == NUM_REQ - 1) ? '0 : o_gnt_idx + ID_W'(1);
    end
  end

endmodule

// File: rtl/dnn_sched.sv
// Shares one two-stage dnn datapath among NUM_REQ requesters with in-order tagged results.
// Define DNN_SCHED_PERF_EN to add the perf_issue_cnt / perf_stall_cnt counters.
module dnn_sched
  import dnn_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*VEC_W-1:0]   req_x,
  output logic signed [X_W-1:0]      dnn_x0,
  output logic signed [X_W-1:0]      dnn_x1,
  output logic signed [X_W-1:0]      dnn_x2,
  output logic signed [X_W-1:0]      dnn_x3,
  output logic                       dnn_in_ready,
  input  logic [RELU_W-1:0]          dnn_y4_relu,
  input  logic [RELU_W-1:0]          dnn_y5_relu,
  input  logic [RELU_W-1:0]          dnn_y6_relu,
  input  logic [RELU_W-1:0]          dnn_y7_relu,
  output logic [AGGR_W-1:0]          dnn_y4_aggr,
  output logic [AGGR_W-1:0]          dnn_y5_aggr,
  output logic [AGGR_W-1:0]          dnn_y6_aggr,
  output logic [AGGR_W-1:0]          dnn_y7_aggr,
  input  logic signed [OUT_W-1:0]    dnn_out0,
  input  logic signed [OUT_W-1:0]    dnn_out1,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [$clog2(NUM_REQ)-1:0] res_id,
`ifdef DNN_SCHED_PERF_EN
  output logic [31:0]                perf_issue_cnt,
  output logic [31:0]                perf_stall_cnt,
`endif
  output logic signed [OUT_W-1:0]    res_out0,
  output logic signed [OUT_W-1:0]    res_out1
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam int CNT_W = $clog2(RES_DEPTH + 1) + 1;

  logic [VEC_W-1:0] w_lane [NUM_REQ];
  logic [VEC_W-1:0] w_sel;
  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_gnt_idx;
  logic             w_issue;
  logic             w_credit_ok;
  logic [CNT_W-1:0] w_used;

  logic             r_v1, r_v2;
  logic [ID_W-1:0]  r_id1, r_id2;

  res_t             r_mem [RES_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  res_t             w_push_data, w_head;
  logic             w_push, w_pop;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign w_lane[gi] = req_x[gi*VEC_W +: VEC_W];
  end

  // Credits cover both queued results and those still inside the datapath.
  assign w_used      = r_count + CNT_W'(r_v1) + CNT_W'(r_v2);
  assign w_credit_ok = w_used < CNT_W'(RES_DEPTH);

  dnn_sched_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_req       (req_valid),
    .i_en        (w_credit_ok),
    .o_gnt       (w_gnt),
    .o_gnt_idx   (w_gnt_idx),
    .o_gnt_valid (w_issue)
  );

  assign req_ready    = w_gnt;
  assign dnn_in_ready = w_issue;
  assign w_sel        = w_issue ? w_lane[w_gnt_idx] : '0;
  assign dnn_x0       = w_sel[0*X_W +: X_W];
  assign dnn_x1       = w_sel[1*X_W +: X_W];
  assign dnn_x2       = w_sel[2*X_W +: X_W];
  assign dnn_x3       = w_sel[3*X_W +: X_W];

  assign dnn_y4_aggr = relu_to_aggr(dnn_y4_relu);
  assign dnn_y5_aggr = relu_to_aggr(dnn_y5_relu);
  assign dnn_y6_aggr = relu_to_aggr(dnn_y6_relu);
  assign dnn_y7_aggr = relu_to_aggr(dnn_y7_relu);

  // The datapath's own ready flags are unreset, so the tag pipe tracks validity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_id1 <= '0;
      r_id2 <= '0;
    end else begin
      r_v1  <= w_issue;
      r_v2  <= r_v1;
      r_id1 <= w_gnt_idx;
      r_id2 <= r_id1;
    end
  end

  assign w_push           = r_v2;
  assign w_pop            = res_valid & res_ready;
  assign w_push_data.id   = MAX_ID_W'(r_id2);
  assign w_push_data.out0 = dnn_out0;
  assign w_push_data.out1 = dnn_out1;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      assert (!(w_push && r_count == CNT_W'(RES_DEPTH)));
      assert (!res_valid || int'(w_head.id) < NUM_REQ);
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign res_valid = (r_count != '0);
  assign res_id    = w_head.id[ID_W-1:0];
  assign res_out0  = w_head.out0;
  assign res_out1  = w_head.out1;

`ifdef DNN_SCHED_PERF_EN
  logic [31:0] r_issue_cnt, r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_issue)                     r_issue_cnt <= r_issue_cnt + 32'd1;
      if (|req_valid && !w_credit_ok) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_issue_cnt = r_issue_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dnn_sched.sv
// Bench for dnn_sched with a behavioural two-stage datapath model and in-order result scoreboard.
// Perf counter checks are compiled in when DNN_SCHED_PERF_EN is defined.
module tb_dnn_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]          req_valid = '0;
  logic [3:0]          req_ready;
  logic [111:0]        req_x = '0;
  logic signed [6:0]   dnn_x0, dnn_x1, dnn_x2, dnn_x3;
  logic                dnn_in_ready;
  logic [14:0]         dnn_y4_relu, dnn_y5_relu, dnn_y6_relu, dnn_y7_relu;
  logic [16:0]         dnn_y4_aggr, dnn_y5_aggr, dnn_y6_aggr, dnn_y7_aggr;
  logic signed [20:0]  dnn_out0, dnn_out1;
  logic                res_valid;
  logic                res_ready = 1'b1;
  logic [1:0]          res_id;
  logic signed [20:0]  res_out0, res_out1;
`ifdef DNN_SCHED_PERF_EN
  logic [31:0]         perf_issue_cnt, perf_stall_cnt;
`endif

  dnn_sched #(.NUM_REQ(4), .RES_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_x        (req_x),
    .dnn_x0       (dnn_x0),
    .dnn_x1       (dnn_x1),
    .dnn_x2       (dnn_x2),
    .dnn_x3       (dnn_x3),
    .dnn_in_ready (dnn_in_ready),
    .dnn_y4_relu  (dnn_y4_relu),
    .dnn_y5_relu  (dnn_y5_relu),
    .dnn_y6_relu  (dnn_y6_relu),
    .dnn_y7_relu  (dnn_y7_relu),
    .dnn_y4_aggr  (dnn_y4_aggr),
    .dnn_y5_aggr  (dnn_y5_aggr),
    .dnn_y6_aggr  (dnn_y6_aggr),
    .dnn_y7_aggr  (dnn_y7_aggr),
    .dnn_out0     (dnn_out0),
    .dnn_out1     (dnn_out1),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_id       (res_id),
`ifdef DNN_SCHED_PERF_EN
    .perf_issue_cnt (perf_issue_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .res_out0     (res_out0),
    .res_out1     (res_out1)
  );

  // Datapath model: layer-1 weights w1[input][node], output weights v0/v1 over the aggregates.
  int w1 [4][4];
  int v0 [4];
  int v1 [4];
  logic [14:0]        m_y [4] = '{default: '0};
  logic signed [20:0] m_out0 = '0;
  logic signed [20:0] m_out1 = '0;

  function automatic int xin(input int i);
    case (i)
      0:       return int'(dnn_x0);
      1:       return int'(dnn_x1);
      2:       return int'(dnn_x2);
      default: return int'(dnn_x3);
    endcase
  endfunction

  function automatic int aggr(input int j);
    case (j)
      0:       return int'(dnn_y4_aggr);
      1:       return int'(dnn_y5_aggr);
      2:       return int'(dnn_y6_aggr);
      default: return int'(dnn_y7_aggr);
    endcase
  endfunction

  function automatic logic [14:0] node(input int j);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s += w1[i][j] * xin(i);
    return (s < 0) ? 15'd0 : 15'(s);
  endfunction

  function automatic logic signed [20:0] dot(input int which);
    int s;
    s = 0;
    for (int j = 0; j < 4; j++) s += ((which == 0) ? v0[j] : v1[j]) * aggr(j);
    return 21'(s);
  endfunction

  always @(posedge clk) begin
    if (dnn_in_ready) begin
      for (int j = 0; j < 4; j++) m_y[j] <= node(j);
    end
    m_out0 <= dot(0);
    m_out1 <= dot(1);
  end

  assign dnn_y4_relu = m_y[0];
  assign dnn_y5_relu = m_y[1];
  assign dnn_y6_relu = m_y[2];
  assign dnn_y7_relu = m_y[3];
  assign dnn_out0    = m_out0;
  assign dnn_out1    = m_out1;

  // Checking infrastructure.
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int id;
    int o0;
    int o1;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_ready;
    int         exp_id;
    int         exp_x0;
    int         exp_o0;
    int         exp_o1;
  } vec_t;
  vec_t tbl [12];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_x(input int r, input int x3, input int x2, input int x1, input int x0);
    req_x[28*r +: 28] = {7'(x3), 7'(x2), 7'(x1), 7'(x0)};
  endtask

  task automatic set_weights(input int l1, input int o0w, input int o1w);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) w1[i][j] = l1;
      v0[i] = o0w;
      v1[i] = o1w;
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    #1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // One isolated issue from requester r with the 3-cycle latency checked along the way.
  task automatic issue_one(input string tag, input int r, input int ex0, input int exp_aggr,
                           input int o0, input int o1);
    req_valid = 4'(1 << r);
    #1;
    check({tag, "_ready"}, int'(req_ready), 1 << r);
    check({tag, "_in_ready"}, int'(dnn_in_ready), 1);
    check({tag, "_x0"}, int'(dnn_x0), ex0);
    if (req_ready[r]) exp_q.push_back('{r, o0, o1});
    tick();
    req_valid = '0;
    #1;
    check({tag, "_y4_aggr"}, int'(dnn_y4_aggr), exp_aggr);
    check({tag, "_lat1"}, int'(res_valid), 0);
    tick();
    check({tag, "_lat2"}, int'(res_valid), 0);
    tick();
    check({tag, "_lat3"}, int'(res_valid), 1);
    check({tag, "_id"}, int'(res_id), r);
    tick();
  endtask

  // Result monitor: every accepted head must match the next expected record.
  always @(negedge clk) begin
    if (!rst && res_valid === 1'b1 && res_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("res_unexpected", 1, 0);
      end else begin
        $display("[TB] result id=%0d out0=%0d out1=%0d", res_id, res_out0, res_out1);
        check("res_id", int'(res_id), exp_q[0].id);
        check("res_out0", int'(res_out0), exp_q[0].o0);
        check("res_out1", int'(res_out1), exp_q[0].o1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the end of the test");
    $fatal(1, "timeout");
  end

  initial begin
    int n_xfer;

    // Reset state.
    set_weights(1, 1, 1);
    tick();
    tick();
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_in_ready", int'(dnn_in_ready), 0);
    check("rst_x0", int'(dnn_x0), 0);
    check("rst_res_valid", int'(res_valid), 0);
    rst = 1'b0;
    tick();

    // Single request, weights all 1: y = 10, out = 4*10.
    set_x(0, 1, 2, 3, 4);
    issue_one("single", 0, 4, 10, 40, 40);

    // Round-robin table. Lane r = {0,-2,1,10+r} -> node sum 9+r, out0 = 4*(9+r), out1 = 2*out0.
    do_reset();
    set_weights(1, 1, 2);
    for (int r = 0; r < 4; r++) set_x(r, 0, -2, 1, 10 + r);
    tbl[0]  = '{4'b1111, 4'b0001, 0, 10, 36, 72};
    tbl[1]  = '{4'b1111, 4'b0010, 1, 11, 40, 80};
    tbl[2]  = '{4'b1111, 4'b0100, 2, 12, 44, 88};
    tbl[3]  = '{4'b1111, 4'b1000, 3, 13, 48, 96};
    tbl[4]  = '{4'b1111, 4'b0001, 0, 10, 36, 72};
    tbl[5]  = '{4'b0000, 4'b0000, 0,  0,  0,  0};
    tbl[6]  = '{4'b0001, 4'b0001, 0, 10, 36, 72};
    tbl[7]  = '{4'b1001, 4'b1000, 3, 13, 48, 96};
    tbl[8]  = '{4'b1001, 4'b0001, 0, 10, 36, 72};
    tbl[9]  = '{4'b0100, 4'b0100, 2, 12, 44, 88};
    tbl[10] = '{4'b0110, 4'b0010, 1, 11, 40, 80};
    tbl[11] = '{4'b0110, 4'b0100, 2, 12, 44, 88};
    for (int i = 0; i < 12; i++) begin
      req_valid = tbl[i].valid;
      #1;
      $display("[TB] vec %0d valid=%b ready=%b x0=%0d", i, req_valid, req_ready, dnn_x0);
      check($sformatf("rr%0d_ready", i), int'(req_ready), int'(tbl[i].exp_ready));
      check($sformatf("rr%0d_in_ready", i), int'(dnn_in_ready), (tbl[i].exp_ready != 4'b0000) ? 1 : 0);
      check($sformatf("rr%0d_x0", i), int'(dnn_x0), tbl[i].exp_x0);
      if (tbl[i].exp_ready != 4'b0000) exp_q.push_back('{tbl[i].exp_id, tbl[i].exp_o0, tbl[i].exp_o1});
      tick();
    end
    req_valid = '0;
    repeat (6) tick();
    check("rr_drain", exp_q.size(), 0);

    // Backpressure: four credits, then blocked for three cycles, then resume.
    do_reset();
    set_weights(1, 1, 1);
    set_x(0, 1, 2, 3, 4);
    res_ready = 1'b0;
    req_valid = 4'b0001;
    n_xfer = 0;
    for (int c = 0; c < 7; c++) begin
      #1;
      check($sformatf("bp%0d_ready", c), int'(req_ready[0]), (c < 4) ? 1 : 0);
      if (req_ready[0]) begin
        n_xfer++;
        exp_q.push_back('{0, 40, 40});
      end
      tick();
    end
    check("bp_xfers", n_xfer, 4);
    req_valid = '0;
    res_ready = 1'b1;
    #1;
    check("bp_head_valid", int'(res_valid), 1);
    tick();
    req_valid = 4'b0001;
    #1;
    check("bp_resume", int'(req_ready), 1);
    if (req_ready[0]) exp_q.push_back('{0, 40, 40});
    tick();
    req_valid = '0;
`ifdef DNN_SCHED_PERF_EN
    check("perf_issue_cnt", int'(perf_issue_cnt), 5);
    check("perf_stall_cnt", int'(perf_stall_cnt), 3);
`endif
    repeat (8) tick();
    check("bp_drain", exp_q.size(), 0);

    // Layer-1 sign handling and zero-extension of the fed-back ReLU outputs.
    do_reset();
    set_weights(0, 1, 1);
    w1[0][0] = 1;
    set_x(2, 0, 0, 0, -5);
    issue_one("neg", 2, -5, 0, 0, 0);
    set_x(2, 0, 0, 0, 5);
    issue_one("pos", 2, 5, 5, 5, 5);
    for (int i = 0; i < 4; i++) w1[i][0] = 127;
    set_x(2, 63, 63, 63, 63);
    issue_one("big", 2, 63, 32004, 32004, 32004);

    // Reset with two issues in flight: nothing may emerge afterwards.
    do_reset();
    set_weights(1, 1, 1);
    set_x(0, 1, 2, 3, 4);
    req_valid = 4'b0001;
    #1;
    check("flush_issue0", int'(dnn_in_ready), 1);
    tick();
    #1;
    check("flush_issue1", int'(dnn_in_ready), 1);
    tick();
    req_valid = '0;
    rst = 1'b1;
    #1;
    check("flush_res_valid", int'(res_valid), 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("flush_quiet%0d", c), int'(res_valid), 0);
      tick();
    end
    issue_one("post_rst", 0, 4, 10, 40, 40);
    check("final_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
